cdb_multi_broadcast: RTL and testbench

//  Multi-lane common data bus. Collects completed results from NUM_FU execute units,

---
 rtl/cdb_multi_broadcast.sv | 161 ++++++++++++++++
 tb/tb_cdb_multi_broadcast.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_multi_broadcast.sv
// Multi-lane common data bus: per-unit result FIFOs feeding NUM_CDB broadcast lanes,
// granted round-robin among non-empty FIFOs, with squash flush.
module cdb_multi_broadcast #(
    parameter int NUM_FU    = 4,
    parameter int NUM_CDB   = 2,
    parameter int BUF_DEPTH = 2,
    parameter int TAG_W     = 6,
    parameter int XLEN      = 32,
    localparam int SRC_W    = $clog2(NUM_FU)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic [NUM_FU-1:0]         fu_valid,
    output logic [NUM_FU-1:0]         fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]   fu_dest_tag,
    input  logic [NUM_FU*XLEN-1:0]    fu_result,
    input  logic [NUM_FU*XLEN-1:0]    fu_npc,
    input  logic [NUM_FU-1:0]         fu_take_branch,
    input  logic [NUM_FU-1:0]         fu_zero_reg,
    input  logic [NUM_FU-1:0]         fu_no_output,
    output logic [NUM_CDB-1:0]        cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    output logic [NUM_CDB-1:0]        cdb_tag_valid,
    output logic [NUM_CDB*XLEN-1:0]   cdb_value,
    output logic [NUM_CDB*XLEN-1:0]   cdb_npc,
    output logic [NUM_CDB-1:0]        cdb_take_branch,
    output logic [NUM_CDB*SRC_W-1:0]  cdb_src_fu
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  npc;
        logic             take_branch;
        logic             zero_reg;
        logic             no_output;
    } entry_t;

    entry_t             mem      [NUM_FU][BUF_DEPTH];
    entry_t             in_entry [NUM_FU];
    logic [PTR_W-1:0]   head     [NUM_FU];
    logic [PTR_W-1:0]   tail     [NUM_FU];
    logic [CNT_W-1:0]   count    [NUM_FU];
    logic [SRC_W-1:0]   lane_fu  [NUM_CDB];
    logic [NUM_CDB-1:0] lane_used;
    logic [NUM_FU-1:0]  push;
    logic [NUM_FU-1:0]  grant;
    logic [NUM_FU-1:0]  nonempty;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   rr_ptr_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Readiness depends only on registered occupancy, so there is no input-to-ready path.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = (count[i] < CNT_W'(BUF_DEPTH));
            nonempty[i] = (count[i] != '0);
            push[i]     = fu_valid[i] & fu_ready[i] & ~squash;
            in_entry[i] = '{tag:         fu_dest_tag[i*TAG_W +: TAG_W],
                            result:      fu_result[i*XLEN +: XLEN],
                            npc:         fu_npc[i*XLEN +: XLEN],
                            take_branch: fu_take_branch[i],
                            zero_reg:    fu_zero_reg[i],
                            no_output:   fu_no_output[i]};
        end
    end

    // Walk units from rr_ptr; the n-th non-empty unit found takes lane n.
    always_comb begin
        int                seen;
        int                pos;
        logic [SRC_W-1:0]  s;
        grant       = '0;
        lane_used   = '0;
        rr_ptr_next = rr_ptr;
        seen        = 0;
        for (int k = 0; k < NUM_CDB; k++) begin
            lane_fu[k] = '0;
        end
        for (int j = 0; j < NUM_FU; j++) begin
            pos = int'(rr_ptr) + j;
            if (pos >= NUM_FU) begin
                pos = pos - NUM_FU;
            end
            s = SRC_W'(pos);
            if (!squash && nonempty[s] && seen < NUM_CDB) begin
                grant[s] = 1'b1;
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (k == seen) begin
                        lane_used[k] = 1'b1;
                        lane_fu[k]   = s;
                    end
                end
                rr_ptr_next = (s == SRC_W'(NUM_FU - 1)) ? '0 : s + SRC_W'(1);
                seen        = seen + 1;
            end
        end
    end

    always_comb begin
        entry_t e;
        cdb_valid       = '0;
        cdb_tag         = '0;
        cdb_tag_valid   = '0;
        cdb_value       = '0;
        cdb_npc         = '0;
        cdb_take_branch = '0;
        cdb_src_fu      = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            e = mem[lane_fu[k]][head[lane_fu[k]]];
            if (lane_used[k]) begin
                cdb_valid[k]                  = 1'b1;
                cdb_tag[k*TAG_W +: TAG_W]     = e.tag;
                cdb_tag_valid[k]              = ~(e.zero_reg | e.no_output);
                cdb_value[k*XLEN +: XLEN]     = e.result;
                cdb_npc[k*XLEN +: XLEN]       = e.take_branch ? e.result : e.npc;
                cdb_take_branch[k]            = e.take_branch;
                cdb_src_fu[k*SRC_W +: SRC_W]  = lane_fu[k];
            end
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are visible.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                mem[i][tail[i]] <= in_entry[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            rr_ptr <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            rr_ptr <= rr_ptr_next;
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) begin
                    tail[i] <= ptr_inc(tail[i]);
                end
                if (grant[i]) begin
                    head[i] <= ptr_inc(head[i]);
                end
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(grant[i]);
            end
        end
    end

endmodule

// File: tb/tb_cdb_multi_broadcast.sv
// Bench for cdb_multi_broadcast: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_cdb_multi_broadcast;

    localparam int NUM_FU    = 4;
    localparam int NUM_CDB   = 2;
    localparam int BUF_DEPTH = 2;
    localparam int TAG_W     = 6;
    localparam int XLEN      = 32;
    localparam int SRC_W     = 2;

    logic                      clock;
    logic                      reset;
    logic                      squash;
    logic [NUM_FU-1:0]         fu_valid;
    logic [NUM_FU-1:0]         fu_ready;
    logic [NUM_FU*TAG_W-1:0]   fu_dest_tag;
    logic [NUM_FU*XLEN-1:0]    fu_result;
    logic [NUM_FU*XLEN-1:0]    fu_npc;
    logic [NUM_FU-1:0]         fu_take_branch;
    logic [NUM_FU-1:0]         fu_zero_reg;
    logic [NUM_FU-1:0]         fu_no_output;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB-1:0]        cdb_tag_valid;
    logic [NUM_CDB*XLEN-1:0]   cdb_value;
    logic [NUM_CDB*XLEN-1:0]   cdb_npc;
    logic [NUM_CDB-1:0]        cdb_take_branch;
    logic [NUM_CDB*SRC_W-1:0]  cdb_src_fu;

    cdb_multi_broadcast #(
        .NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB), .BUF_DEPTH(BUF_DEPTH),
        .TAG_W(TAG_W), .XLEN(XLEN)
    ) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_dest_tag(fu_dest_tag), .fu_result(fu_result), .fu_npc(fu_npc),
        .fu_take_branch(fu_take_branch), .fu_zero_reg(fu_zero_reg),
        .fu_no_output(fu_no_output),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_tag_valid(cdb_tag_valid),
        .cdb_value(cdb_value), .cdb_npc(cdb_npc), .cdb_take_branch(cdb_take_branch),
        .cdb_src_fu(cdb_src_fu)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: one queue per unit, round-robin pointer as a plain integer.
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  npc;
        logic             tb;
        logic             zr;
        logic             no;
    } ent_t;

    ent_t q [NUM_FU][$];
    int   rr = 0;
    bit   live = 0;
    int   g_src [NUM_CDB];
    int   g_n;

    function automatic void computeGrants();
        int u;
        g_n = 0;
        for (int j = 0; j < NUM_FU; j++) begin
            u = (rr + j) % NUM_FU;
            if (q[u].size() > 0 && g_n < NUM_CDB) begin
                g_src[g_n] = u;
                g_n++;
            end
        end
    endfunction

    always @(posedge clock) begin
        bit   rdy [NUM_FU];
        ent_t e;
        if (reset) begin
            for (int i = 0; i < NUM_FU; i++) q[i].delete();
            rr   = 0;
            live = 1;
        end else if (squash) begin
            for (int i = 0; i < NUM_FU; i++) q[i].delete();
            rr = 0;
        end else if (live) begin
            for (int i = 0; i < NUM_FU; i++) rdy[i] = (q[i].size() < BUF_DEPTH);
            computeGrants();
            for (int k = 0; k < g_n; k++) void'(q[g_src[k]].pop_front());
            if (g_n > 0) rr = (g_src[g_n-1] + 1) % NUM_FU;
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && rdy[i]) begin
                    e.tag    = fu_dest_tag[i*TAG_W +: TAG_W];
                    e.result = fu_result[i*XLEN +: XLEN];
                    e.npc    = fu_npc[i*XLEN +: XLEN];
                    e.tb     = fu_take_branch[i];
                    e.zr     = fu_zero_reg[i];
                    e.no     = fu_no_output[i];
                    q[i].push_back(e);
                end
            end
        end
    end

    logic [NUM_CDB-1:0]       exp_valid, exp_tv, exp_tb;
    logic [NUM_CDB*TAG_W-1:0] exp_tag;
    logic [NUM_CDB*XLEN-1:0]  exp_val, exp_npc;
    logic [NUM_CDB*SRC_W-1:0] exp_src;
    logic [NUM_FU-1:0]        exp_ready;

    always @(negedge clock) begin
        ent_t e;
        if (live) begin
            exp_valid = '0; exp_tv = '0; exp_tb = '0; exp_tag = '0;
            exp_val = '0; exp_npc = '0; exp_src = '0;
            for (int i = 0; i < NUM_FU; i++) exp_ready[i] = (q[i].size() < BUF_DEPTH);
            if (!squash) begin
                computeGrants();
                for (int k = 0; k < g_n; k++) begin
                    e = q[g_src[k]][0];
                    exp_valid[k]                 = 1'b1;
                    exp_tag[k*TAG_W +: TAG_W]    = e.tag;
                    exp_tv[k]                    = !(e.zr || e.no);
                    exp_val[k*XLEN +: XLEN]      = e.result;
                    exp_npc[k*XLEN +: XLEN]      = e.tb ? e.result : e.npc;
                    exp_tb[k]                    = e.tb;
                    exp_src[k*SRC_W +: SRC_W]    = 2'(g_src[k]);
                end
            end
            checkOutput("model fu_ready", 64'(fu_ready), 64'(exp_ready));
            checkOutput("model cdb_valid", 64'(cdb_valid), 64'(exp_valid));
            checkOutput("model cdb_tag", 64'(cdb_tag), 64'(exp_tag));
            checkOutput("model cdb_tag_valid", 64'(cdb_tag_valid), 64'(exp_tv));
            checkOutput("model cdb_value", 64'(cdb_value), 64'(exp_val));
            checkOutput("model cdb_npc", 64'(cdb_npc), 64'(exp_npc));
            checkOutput("model cdb_take_branch", 64'(cdb_take_branch), 64'(exp_tb));
            checkOutput("model cdb_src_fu", 64'(cdb_src_fu), 64'(exp_src));
        end
    end

    // Per-unit drive registers packed onto the DUT buses by applyStimulus.
    logic [NUM_FU-1:0] drv_valid;
    logic [TAG_W-1:0]  drv_tag [NUM_FU];
    logic [XLEN-1:0]   drv_res [NUM_FU];
    logic [XLEN-1:0]   drv_npc [NUM_FU];
    logic [NUM_FU-1:0] drv_tb, drv_zr, drv_no;

    task automatic clearUnits();
        drv_valid = '0; drv_tb = '0; drv_zr = '0; drv_no = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            drv_tag[i] = '0; drv_res[i] = '0; drv_npc[i] = '0;
        end
    endtask

    task automatic setUnit(input int i, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] res,
                           input logic [XLEN-1:0] npc, input logic tb, input logic zr, input logic no);
        drv_valid[i] = 1'b1;
        drv_tag[i]   = tag;
        drv_res[i]   = res;
        drv_npc[i]   = npc;
        drv_tb[i]    = tb;
        drv_zr[i]    = zr;
        drv_no[i]    = no;
    endtask

    task automatic applyStimulus();
        fu_valid       = drv_valid;
        fu_take_branch = drv_tb;
        fu_zero_reg    = drv_zr;
        fu_no_output   = drv_no;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_dest_tag[i*TAG_W +: TAG_W] = drv_tag[i];
            fu_result[i*XLEN +: XLEN]     = drv_res[i];
            fu_npc[i*XLEN +: XLEN]        = drv_npc[i];
        end
        @(negedge clock);
    endtask

    task automatic endCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        clearUnits();
        for (int c = 0; c < n; c++) begin
            applyStimulus();
            endCycle();
        end
    endtask

    int seq [NUM_FU];

    initial begin
        reset  = 1'b1;
        squash = 1'b0;
        clearUnits();
        applyStimulus();
        endCycle();
        endCycle();
        reset = 1'b0;

        // Reset then idle
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput("idle cdb_valid", 64'(cdb_valid), 64'h0);
            checkOutput("idle fu_ready", 64'(fu_ready), 64'hF);
            endCycle();
        end

        // Single taken-branch result from unit 2
        clearUnits();
        setUnit(2, 6'd5, 32'h40, 32'h10, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("push-cycle cdb_valid", 64'(cdb_valid), 64'h0);
        endCycle();
        clearUnits();
        applyStimulus();
        checkOutput("u2 cdb_valid", 64'(cdb_valid), 64'h1);
        checkOutput("u2 cdb_tag", 64'(cdb_tag), 64'h005);
        checkOutput("u2 cdb_tag_valid", 64'(cdb_tag_valid), 64'h1);
        checkOutput("u2 cdb_npc", 64'(cdb_npc), 64'h40);
        checkOutput("u2 cdb_value", 64'(cdb_value), 64'h40);
        checkOutput("u2 cdb_src_fu", 64'(cdb_src_fu), 64'h2);
        endCycle();
        idle(1);

        // Idle squash returns the pointer to unit 0
        squash = 1'b1;
        idle(1);
        squash = 1'b0;

        // All four units at once
        clearUnits();
        for (int i = 0; i < NUM_FU; i++)
            setUnit(i, 6'(8 + i), 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0);
        applyStimulus();
        endCycle();
        clearUnits();
        applyStimulus();
        checkOutput("all4 first src", 64'(cdb_src_fu), 64'b0100);
        checkOutput("all4 first valid", 64'(cdb_valid), 64'h3);
        endCycle();
        applyStimulus();
        checkOutput("all4 second src", 64'(cdb_src_fu), 64'b1110);
        checkOutput("all4 second npc", 64'(cdb_npc), {32'h203, 32'h202});
        endCycle();
        applyStimulus();
        checkOutput("all4 drained", 64'(cdb_valid), 64'h0);
        endCycle();
        setUnit(0, 6'd20, 32'h11, 32'h12, 1'b0, 1'b0, 1'b0);
        setUnit(3, 6'd23, 32'h31, 32'h32, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        endCycle();
        clearUnits();
        applyStimulus();
        checkOutput("rr back to 0 src", 64'(cdb_src_fu), 64'b1100);
        endCycle();
        idle(2);
        squash = 1'b1;
        idle(1);
        squash = 1'b0;

        // Unit 1 back-to-back under contention with held push
        for (int i = 0; i < NUM_FU; i++) seq[i] = 0;
        for (int c = 0; c < 12; c++) begin
            clearUnits();
            for (int i = 0; i < NUM_FU; i++) begin
                if ((i != 1 && c < 5) || (i == 1 && c >= 1 && seq[1] < 3))
                    setUnit(i, 6'(i*8 + seq[i]), 32'h1000*32'(i) + 32'(seq[i]),
                            32'h1000*32'(i) + 32'(seq[i]) + 32'h4, seq[i][0], 1'b0, 1'b0);
            end
            applyStimulus();
            if (c == 2) checkOutput("contend C ready", 64'(fu_ready), 64'b0111);
            if (c == 3) checkOutput("contend D ready", 64'(fu_ready), 64'b1001);
            if (c == 4) checkOutput("contend E ready", 64'(fu_ready), 64'b0110);
            for (int i = 0; i < NUM_FU; i++)
                if (drv_valid[i] && fu_ready[i]) seq[i]++;
            endCycle();
        end
        checkOutput("unit1 accepted", 64'(seq[1]), 64'd3);

        // Zero-register and no-output results
        clearUnits();
        setUnit(0, 6'd0, 32'h77, 32'h80, 1'b0, 1'b1, 1'b0);
        setUnit(3, 6'd9, 32'h88, 32'h90, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        endCycle();
        clearUnits();
        applyStimulus();
        checkOutput("noreg cdb_valid", 64'(cdb_valid), 64'h3);
        checkOutput("noreg cdb_tag_valid", 64'(cdb_tag_valid), 64'h0);
        endCycle();
        idle(2);

        // Five buffered entries, then squash with a concurrent push
        clearUnits();
        for (int i = 0; i < NUM_FU; i++)
            setUnit(i, 6'(40 + i), 32'h500 + 32'(i), 32'h600, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        endCycle();
        clearUnits();
        for (int i = 0; i < 3; i++)
            setUnit(i, 6'(50 + i), 32'h700 + 32'(i), 32'h800, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        endCycle();
        clearUnits();
        setUnit(0, 6'd60, 32'h900, 32'h904, 1'b0, 1'b0, 1'b0);
        squash = 1'b1;
        applyStimulus();
        checkOutput("squash cdb_valid", 64'(cdb_valid), 64'h0);
        endCycle();
        squash = 1'b0;
        clearUnits();
        applyStimulus();
        checkOutput("post-squash fu_ready", 64'(fu_ready), 64'hF);
        checkOutput("post-squash cdb_valid", 64'(cdb_valid), 64'h0);
        endCycle();
        idle(3);

        // Reset mid-stream discards buffered entries
        clearUnits();
        for (int i = 0; i < NUM_FU; i++)
            setUnit(i, 6'(30 + i), 32'hA0 + 32'(i), 32'hB0, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        endCycle();
        reset = 1'b1;
        applyStimulus();
        endCycle();
        reset = 1'b0;
        clearUnits();
        applyStimulus();
        checkOutput("post-reset cdb_valid", 64'(cdb_valid), 64'h0);
        checkOutput("post-reset fu_ready", 64'(fu_ready), 64'hF);
        endCycle();
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
